// File: rtl/knapsack_search_ctrl.sv
// ---------------------------------------------------------------------------
// knapsack_search_ctrl
//
// Exhaustive-search sequencer for a combinational knapsack evaluator.
// After an accepted start it presents every item subset (0 .. 2**N_ITEMS-1)
// on cand_sel, one per clock. It records the highest-value feasible subset
// and the number of feasible subsets. It is the only driver of the
// evaluator's item-select inputs.
//
// Handshake: start is a level that is sampled only in IDLE. Once it is
// accepted, busy stays high for 2**N_ITEMS cycles. done then pulses for
// exactly one cycle and the results are valid. A start seen in SCAN or DONE
// is dropped and is not queued. An abort in SCAN returns to IDLE with the
// results cleared and no done pulse.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start, abort        host control
//   cand_sel            subset under test (bit0 = item A); 0 outside SCAN
//   eval_fit/eval_value combinational evaluator response to cand_sel
//   busy, done          scan in progress / one-cycle completion pulse
//   found, best_sel,    results of the last completed scan
//   best_value, fit_count
//   state_dbg           current FSM state (0 IDLE, 1 SCAN, 2 DONE)
// ---------------------------------------------------------------------------
module knapsack_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int VAL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [N_ITEMS-1:0] cand_sel,
  input  logic               eval_fit,
  input  logic [VAL_W-1:0]   eval_value,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_sel,
  output logic [VAL_W-1:0]   best_value,
  output logic [N_ITEMS:0]   fit_count,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N_ITEMS-1:0] CNT_LAST = '1;
  localparam logic [N_ITEMS-1:0] CNT_ONE  = N_ITEMS'(1);
  localparam logic [N_ITEMS:0]   FIT_ONE  = (N_ITEMS+1)'(1);

  state_t             state_q, state_d;
  logic [N_ITEMS-1:0] cnt_q, cnt_d;
  logic               found_q, found_d;
  logic [N_ITEMS-1:0] best_sel_q, best_sel_d;
  logic [VAL_W-1:0]   best_val_q, best_val_d;
  logic [N_ITEMS:0]   fit_cnt_q, fit_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      best_sel_q <= '0;
      best_val_q <= '0;
      fit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      best_sel_q <= best_sel_d;
      best_val_q <= best_val_d;
      fit_cnt_q  <= fit_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    best_sel_d = best_sel_q;
    best_val_d = best_val_q;
    fit_cnt_d  = fit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Previous results stay visible until the next accepted start.
        // If start and abort arrive together, start wins.
        if (start) begin
          state_d    = ST_SCAN;
          cnt_d      = '0;
          found_d    = 1'b0;
          best_sel_d = '0;
          best_val_d = '0;
          fit_cnt_d  = '0;
        end
      end

      ST_SCAN: begin
        if (abort) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          found_d    = 1'b0;
          best_sel_d = '0;
          best_val_d = '0;
          fit_cnt_d  = '0;
        end else begin
          if (eval_fit) begin
            fit_cnt_d = fit_cnt_q + FIT_ONE;
            // Strictly greater: on a tie the lower subset, which was seen
            // first, is kept.
            if (!found_q || (eval_value > best_val_q)) begin
              found_d    = 1'b1;
              best_sel_d = cnt_q;
              best_val_d = eval_value;
            end
          end
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cand_sel   = (state_q == ST_SCAN) ? cnt_q : '0;
  assign busy       = (state_q == ST_SCAN);
  assign done       = (state_q == ST_DONE);
  assign found      = found_q;
  assign best_sel   = best_sel_q;
  assign best_value = best_val_q;
  assign fit_count  = fit_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_knapsack_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_knapsack_search_ctrl
//
// Bench for knapsack_search_ctrl. The evaluator is a lookup table indexed by
// cand_sel. The table is filled with the real knapsack rule, a constant stub,
// or random contents. Expected results come from a fixed vector table and
// from a reference model that works on the whole table (maximum value, then
// the lowest subset that reaches it).
// ---------------------------------------------------------------------------
module tb_knapsack_search_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [4:0] cand_sel;
  logic       eval_fit;
  logic [5:0] eval_value;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] best_sel;
  logic [5:0] best_value;
  logic [5:0] fit_count;
  logic [1:0] state_dbg;

  knapsack_search_ctrl #(.N_ITEMS(5), .VAL_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cand_sel   (cand_sel),
    .eval_fit   (eval_fit),
    .eval_value (eval_value),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .best_sel   (best_sel),
    .best_value (best_value),
    .fit_count  (fit_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // evaluator model
  logic       fit_tab [32];
  logic [5:0] val_tab [32];

  always_comb begin
    eval_fit   = fit_tab[cand_sel];
    eval_value = val_tab[cand_sel];
  end

  int wt_a [5] = '{12, 1, 2, 1, 4};
  int vl_a [5] = '{4, 2, 2, 1, 10};

  task automatic fill_knapsack(input int thr);
    for (int s = 0; s < 32; s++) begin
      int w;
      int v;
      w = 0;
      v = 0;
      for (int i = 0; i < 5; i++) begin
        if (((s >> i) & 1) == 1) begin
          w += wt_a[i];
          v += vl_a[i];
        end
      end
      fit_tab[s] = (w <= 16) && (v > thr);
      val_tab[s] = 6'(v);
    end
  endtask

  task automatic fill_const(input logic f, input int v);
    for (int s = 0; s < 32; s++) begin
      fit_tab[s] = f;
      val_tab[s] = 6'(v);
    end
  endtask

  task automatic fill_random(input bit dense);
    for (int s = 0; s < 32; s++) begin
      if (dense) begin
        fit_tab[s] = ($urandom_range(0, 3) != 0);
        val_tab[s] = 6'($urandom_range(0, 3));
      end else begin
        fit_tab[s] = 1'($urandom_range(0, 1));
        val_tab[s] = 6'($urandom_range(0, 63));
      end
    end
  endtask

  // reference model: packs {found, best_sel, best_value, fit_count}
  function automatic logic [17:0] ref_model();
    int cnt;
    int maxv;
    int sel;
    cnt  = 0;
    maxv = -1;
    sel  = 0;
    for (int s = 0; s < 32; s++) begin
      if (fit_tab[s]) begin
        cnt++;
        if (int'(val_tab[s]) > maxv) maxv = int'(val_tab[s]);
      end
    end
    if (cnt == 0) return 18'd0;
    for (int s = 31; s >= 0; s--) begin
      if (fit_tab[s] && int'(val_tab[s]) == maxv) sel = s;
    end
    return {1'b1, 5'(sel), 6'(maxv), 6'(cnt)};
  endfunction

  // scoreboard
  logic [17:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
    check({tag, "_found"},      32'(found), 32'd0);
    check({tag, "_best_sel"},   32'(best_sel), 32'd0);
    check({tag, "_best_value"}, 32'(best_value), 32'd0);
    check({tag, "_fit_count"},  32'(fit_count), 32'd0);
    check({tag, "_cand_sel"},   32'(cand_sel), 32'd0);
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a scan and follow it. Returns the number of edges after the start
  // sampling edge until done is visible, whether done came at all, and
  // whether cand_sel walked 0,1,2,... with busy high.
  task automatic run_scan(output int lat, output bit ok, output bit seq_ok);
    pulse_start();
    seq_ok = (busy === 1'b1) && (cand_sel === 5'd0);
    lat    = 0;
    ok     = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        ok  = 1'b1;
        break;
      end
      if (busy !== 1'b1 || cand_sel !== 5'(k)) seq_ok = 1'b0;
    end
  endtask

  task automatic full_scan(input string tag);
    int          lat;
    bit          ok;
    bit          seq_ok;
    logic [17:0] exp;
    run_scan(lat, ok, seq_ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    // Edge 32 after the start edge: done is the 33rd cycle counting the
    // cycle in which start was driven.
    check({tag, "_latency"}, 32'(lat), 32'd32);
    check({tag, "_cand_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    exp = exp_q.pop_front();
    check({tag, "_found"},      32'(found), 32'(exp[17]));
    check({tag, "_best_sel"},   32'(best_sel), 32'(exp[16:12]));
    check({tag, "_best_value"}, 32'(best_value), 32'(exp[11:6]));
    check({tag, "_fit_count"},  32'(fit_count), 32'(exp[5:0]));
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(state_dbg), 32'd0);
  endtask

  // directed vector table
  typedef struct {
    int         kind;   // 0 knapsack with value > thr, 1 constant fit=1 value=thr
    int         thr;
    logic       exp_found;
    logic [4:0] exp_sel;
    logic [5:0] exp_val;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{kind: 0, thr: 13, exp_found: 1'b1, exp_sel: 5'b11110, exp_val: 6'd15, exp_cnt: 6'd3};
    vecs[1] = '{kind: 0, thr: 15, exp_found: 1'b0, exp_sel: 5'b00000, exp_val: 6'd0,  exp_cnt: 6'd0};
    vecs[2] = '{kind: 1, thr: 7,  exp_found: 1'b1, exp_sel: 5'b00000, exp_val: 6'd7,  exp_cnt: 6'd32};
    vecs[3] = '{kind: 0, thr: 14, exp_found: 1'b1, exp_sel: 5'b11110, exp_val: 6'd15, exp_cnt: 6'd1};
    vecs[4] = '{kind: 1, thr: 63, exp_found: 1'b1, exp_sel: 5'b00000, exp_val: 6'd63, exp_cnt: 6'd32};

    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    fill_const(1'b0, 0);

    // reset with start held: start must be ignored
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);
    check("post_reset_state", 32'(state_dbg), 32'd0);

    // table-driven scans
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].kind == 0) fill_knapsack(vecs[i].thr);
      else fill_const(1'b1, vecs[i].thr);
      exp_q.push_back({vecs[i].exp_found, vecs[i].exp_sel, vecs[i].exp_val, vecs[i].exp_cnt});
      full_scan($sformatf("vec%0d", i));
    end

    // abort in IDLE is ignored; results of the last scan hold
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_found", 32'(found), 32'd1);
    check("abort_idle_value", 32'(best_value), 32'd63);
    check("abort_idle_count", 32'(fit_count), 32'd32);

    // start and abort together in IDLE: start wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_beats_abort", 32'(busy), 32'd1);
    repeat (40) @(negedge clk);
    check("start_beats_abort_end", 32'(busy), 32'd0);

    // abort at scan cycle 10 clears everything, no done
    fill_const(1'b1, 7);
    begin
      int n_done;
      pulse_start();
      repeat (9) @(negedge clk);
      check("abort_pre_found", 32'(found), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_zero("abort");
      n_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) n_done++;
      end
      check("abort_no_done", 32'(n_done), 32'd0);
    end
    exp_q.push_back(ref_model());
    full_scan("after_abort");

    // start re-pulsed in SCAN and in the DONE cycle: exactly one done
    fill_knapsack(13);
    begin
      int n_done;
      pulse_start();
      n_done = 0;
      for (int c = 0; c < 60; c++) begin
        if (done === 1'b1) n_done++;
        start = (c == 5) || (done === 1'b1);
        @(negedge clk);
      end
      start = 1'b0;
      check("repulse_one_done", 32'(n_done), 32'd1);
      check("repulse_idle", 32'(busy), 32'd0);
      check("repulse_best_sel", 32'(best_sel), 32'b11110);
    end

    // randomized tables against the reference model
    for (int r = 0; r < 12; r++) begin
      fill_random((r % 3) == 0);
      exp_q.push_back(ref_model());
      full_scan($sformatf("rand%0d", r));
    end

    // reset at scan cycle 20
    fill_const(1'b1, 5);
    pulse_start();
    repeat (19) @(negedge clk);
    check("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    check("midrst_stays_idle", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
